// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4 run controller slice.
//   - host command opcodes carried on cmd_op
//   - sequencer state encodings, also presented on run_state
package td4_pkg;

    localparam logic [2:0] CMD_SET_WADDR = 3'd0;
    localparam logic [2:0] CMD_WRITE_NIB = 3'd1;
    localparam logic [2:0] CMD_RUN       = 3'd2;
    localparam logic [2:0] CMD_STEP      = 3'd3;
    localparam logic [2:0] CMD_HALT      = 3'd4;
    localparam logic [2:0] CMD_SET_BP    = 3'd5;
    localparam logic [2:0] CMD_CLR_BP    = 3'd6;
    localparam logic [2:0] CMD_CPU_RESET = 3'd7;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } run_state_t;

endpackage

// File: rtl/td4_prog_ram.sv
// td4_prog_ram: 16x8 program store for the TD4 core.
// Ports:
//   clk, n_reset       clock, asynchronous active-low clear of all words
//   we, waddr, wdata   single synchronous write port
//   raddr, rdata       combinational read port (write visible next cycle)
module td4_prog_ram (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [16];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mem <= '{default: 8'h00};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_run_controller.sv
// td4_run_controller: program store loader and execution sequencer for the
// TD4 core. The host loads bytes as nibble pairs, then runs, steps or halts
// the core; the core only advances on a cpu_en pulse.
// Ports:
//   clk, n_reset                  clock, asynchronous active-low reset
//   cmd_valid/cmd_op/cmd_data     host command; accepted when cmd_ready high
//   cmd_ready                     low only during the single STEP cycle
//   cpu_addr, cpu_instr           core PC in, mem[cpu_addr] out (combinational)
//   cpu_en                        one-cycle execute pulse (registered)
//   cpu_rst_n                     one-cycle core reset request (registered)
//   run_state                     0=HALT 1=RUN 2=STEP
//   bp_hit                        sticky: last halt came from the breakpoint
//   exec_count                    number of cpu_en pulses, wraps at 8 bits
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_HALT | core frozen; program store writable; accepts RUN/STEP
// ST_RUN  | cpu_en every RUN_DIV cycles until HALT or breakpoint
// ST_STEP | one cycle with cpu_en high, then back to HALT
module td4_run_controller
    import td4_pkg::*;
#(
    parameter int RUN_DIV = 4,
    parameter int DIV_W   = 8
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       cmd_ready,
    input  logic [3:0] cpu_addr,
    output logic [7:0] cpu_instr,
    output logic       cpu_en,
    output logic       cpu_rst_n,
    output logic [1:0] run_state,
    output logic       bp_hit,
    output logic [7:0] exec_count
);

    run_state_t       state;
    logic [DIV_W-1:0] prescaler;
    logic [3:0]       wr_addr;
    logic [3:0]       hold;
    logic             half;
    logic [3:0]       bp_addr;
    logic             bp_en;
    logic             skip_bp;

    logic accept;
    logic tick;
    logic ram_we;

    assign cmd_ready = (state != ST_STEP);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (state == ST_RUN) && (prescaler == DIV_W'(RUN_DIV - 1));
    assign ram_we    = accept && (cmd_op == CMD_WRITE_NIB) && (state == ST_HALT) && half;
    assign run_state = state;

    td4_prog_ram u_ram (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (ram_we),
        .waddr   (wr_addr),
        .wdata   ({hold, cmd_data}),
        .raddr   (cpu_addr),
        .rdata   (cpu_instr)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_HALT;
            prescaler  <= '0;
            wr_addr    <= '0;
            hold       <= '0;
            half       <= 1'b0;
            bp_addr    <= '0;
            bp_en      <= 1'b0;
            skip_bp    <= 1'b0;
            cpu_en     <= 1'b0;
            cpu_rst_n  <= 1'b1;
            bp_hit     <= 1'b0;
            exec_count <= '0;
        end else begin
            cpu_en    <= 1'b0;
            cpu_rst_n <= 1'b1;

            // Sequencer progress; command handling below overrides it.
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        prescaler <= '0;
                        if (bp_en && (cpu_addr == bp_addr) && !skip_bp) begin
                            state  <= ST_HALT;
                            bp_hit <= 1'b1;
                        end else begin
                            cpu_en     <= 1'b1;
                            exec_count <= exec_count + 8'd1;
                            skip_bp    <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                ST_STEP: state <= ST_HALT;
                default: ;
            endcase

            if (accept) begin
                case (cmd_op)
                    CMD_SET_WADDR: begin
                        wr_addr <= cmd_data;
                        half    <= 1'b0;
                    end
                    CMD_WRITE_NIB: begin
                        if (state == ST_HALT) begin
                            if (!half) begin
                                hold <= cmd_data;
                                half <= 1'b1;
                            end else begin
                                wr_addr <= wr_addr + 4'd1;
                                half    <= 1'b0;
                            end
                        end
                    end
                    CMD_RUN: begin
                        if (state == ST_HALT) begin
                            state     <= ST_RUN;
                            prescaler <= '0;
                            bp_hit    <= 1'b0;
                            // Lets a resume execute the instruction it stopped on.
                            skip_bp   <= 1'b1;
                        end
                    end
                    CMD_STEP: begin
                        if (state == ST_HALT) begin
                            state      <= ST_STEP;
                            cpu_en     <= 1'b1;
                            exec_count <= exec_count + 8'd1;
                        end
                    end
                    CMD_HALT: begin
                        // Cancels a RUN tick landing in the same cycle.
                        state      <= ST_HALT;
                        prescaler  <= '0;
                        cpu_en     <= 1'b0;
                        exec_count <= exec_count;
                    end
                    CMD_SET_BP: begin
                        bp_addr <= cmd_data;
                        bp_en   <= 1'b1;
                    end
                    CMD_CLR_BP: begin
                        bp_en  <= 1'b0;
                        bp_hit <= 1'b0;
                    end
                    CMD_CPU_RESET: begin
                        cpu_rst_n  <= 1'b0;
                        exec_count <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_td4_run_controller.sv
// Self-checking bench for td4_run_controller. Expected cpu_en pulses
// (instruction seen and exec_count) are queued by the stimulus and popped by
// a monitor whenever the DUT raises cpu_en.
module tb_td4_run_controller;
    import td4_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_data = '0;
    logic       cmd_ready;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_instr;
    logic       cpu_en;
    logic       cpu_rst_n;
    logic [1:0] run_state;
    logic       bp_hit;
    logic [7:0] exec_count;

    logic [3:0] addr_sel = '0;
    logic [3:0] pc = '0;
    logic       pc_follow = 1'b0;
    assign cpu_addr = pc_follow ? pc : addr_sel;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] cnt;
    } rec_t;
    rec_t exp_q[$];
    rec_t mon_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    td4_run_controller #(.RUN_DIV(4), .DIV_W(8)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .cpu_addr   (cpu_addr),
        .cpu_instr  (cpu_instr),
        .cpu_en     (cpu_en),
        .cpu_rst_n  (cpu_rst_n),
        .run_state  (run_state),
        .bp_hit     (bp_hit),
        .exec_count (exec_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] instr, input logic [7:0] cnt);
        rec_t r;
        r.instr = instr;
        r.cnt   = cnt;
        exp_q.push_back(r);
    endtask

    // Drives one command; returns at the falling edge after it was accepted.
    task automatic issue(input logic [2:0] op, input logic [3:0] d);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        issue(CMD_WRITE_NIB, b[7:4]);
        issue(CMD_WRITE_NIB, b[3:0]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (n_reset && cpu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cpu_en: got pulse expected none at %0t", $time);
            end else begin
                mon_r = exp_q.pop_front();
                check("pulse_instr", 32'(cpu_instr), 32'(mon_r.instr));
                check("pulse_count", 32'(exec_count), 32'(mon_r.cnt));
            end
            if (pc_follow) pc = pc + 4'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_run_state", 32'(run_state), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 1);
        n_reset = 1'b1;
        @(negedge clk);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        check("rst_exec_count", 32'(exec_count), 0);
        check("rst_mem0", 32'(cpu_instr), 0);

        // Load
        issue(CMD_SET_WADDR, 4'd0);
        write_byte(8'hB7);
        write_byte(8'h01);
        addr_sel = 4'd0; #1;
        check("load_mem0", 32'(cpu_instr), 32'h0B7);
        addr_sel = 4'd1; #1;
        check("load_mem1", 32'(cpu_instr), 32'h001);
        write_byte(8'h5A);
        addr_sel = 4'd2; #1;
        check("load_waddr2", 32'(cpu_instr), 32'h05A);

        // Address wrap
        issue(CMD_SET_WADDR, 4'd15);
        write_byte(8'hFF);
        write_byte(8'h12);
        addr_sel = 4'd15; #1;
        check("wrap_mem15", 32'(cpu_instr), 32'h0FF);
        addr_sel = 4'd0; #1;
        check("wrap_mem0", 32'(cpu_instr), 32'h012);

        // Run rate: pulses 4,8,12,16,20 cycles after acceptance
        for (int i = 1; i <= 5; i++) push(8'h12, 8'(i));
        issue(CMD_RUN, 4'd0);
        check("run_state_run", 32'(run_state), 1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check($sformatf("run_rate_c%0d", i), 32'(cpu_en), (i % 4 == 0) ? 1 : 0);
        end
        check("run_count5", 32'(exec_count), 5);
        issue(CMD_HALT, 4'd0);
        repeat (10) @(negedge clk);
        check("halt_state", 32'(run_state), 0);
        check("halt_count", 32'(exec_count), 5);

        // Single step
        push(8'h12, 8'd6);
        issue(CMD_STEP, 4'd0);
        check("step_en", 32'(cpu_en), 1);
        check("step_ready", 32'(cmd_ready), 0);
        check("step_state", 32'(run_state), 2);
        @(negedge clk);
        check("step_back_halt", 32'(run_state), 0);
        check("step_en_off", 32'(cpu_en), 0);
        check("step_ready_on", 32'(cmd_ready), 1);

        // STEP / WRITE_NIB ignored in RUN; HALT cancels the coincident tick
        push(8'h12, 8'd7);
        issue(CMD_RUN, 4'd0);
        issue(CMD_STEP, 4'd0);
        check("run_step_ignored", 32'(run_state), 1);
        write_byte(8'hAB);
        issue(CMD_HALT, 4'd0);
        repeat (6) @(negedge clk);
        check("halt_prio_count", 32'(exec_count), 7);
        addr_sel = 4'd1; #1;
        check("run_write_ignored", 32'(cpu_instr), 32'h001);

        // Breakpoint at 3 with PC following cpu_en
        issue(CMD_SET_WADDR, 4'd2);
        write_byte(8'h23);
        write_byte(8'h34);
        write_byte(8'h45);
        issue(CMD_SET_BP, 4'd3);
        push(8'h12, 8'd8);
        push(8'h01, 8'd9);
        push(8'h23, 8'd10);
        pc_follow = 1'b1;
        issue(CMD_RUN, 4'd0);
        guard = 0;
        while (run_state != 2'd0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("bp_halt_timeout", 32'(guard < 60), 1);
        check("bp_pc", 32'(pc), 3);
        check("bp_hit", 32'(bp_hit), 1);
        check("bp_state", 32'(run_state), 0);
        check("bp_count", 32'(exec_count), 10);
        push(8'h34, 8'd11);
        issue(CMD_RUN, 4'd0);
        check("resume_bp_clear", 32'(bp_hit), 0);
        guard = 0;
        while (pc != 4'd4 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("resume_timeout", 32'(guard < 60), 1);
        issue(CMD_HALT, 4'd0);
        repeat (6) @(negedge clk);
        check("resume_pc", 32'(pc), 4);
        check("resume_count", 32'(exec_count), 11);
        issue(CMD_CLR_BP, 4'd0);
        pc_follow = 1'b0;
        addr_sel  = 4'd0;

        // CPU_RESET during RUN
        push(8'h12, 8'd1);
        issue(CMD_RUN, 4'd0);
        issue(CMD_CPU_RESET, 4'd0);
        check("cpurst_low", 32'(cpu_rst_n), 0);
        check("cpurst_count0", 32'(exec_count), 0);
        check("cpurst_state", 32'(run_state), 1);
        @(negedge clk);
        check("cpurst_one_cycle", 32'(cpu_rst_n), 1);
        issue(CMD_HALT, 4'd0);
        repeat (6) @(negedge clk);
        check("cpurst_then_count", 32'(exec_count), 1);

        // Async reset mid-run
        issue(CMD_RUN, 4'd0);
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("rst_midrun_state", 32'(run_state), 0);
        check("rst_midrun_count", 32'(exec_count), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        // Async reset mid-load discards the held nibble
        issue(CMD_SET_WADDR, 4'd5);
        issue(CMD_WRITE_NIB, 4'hC);
        reset_pulse();
        addr_sel = 4'd5; #1;
        check("rst_mem_cleared", 32'(cpu_instr), 0);
        write_byte(8'h96);
        addr_sel = 4'd0; #1;
        check("rst_half_cleared", 32'(cpu_instr), 32'h096);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
